instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Holds the program counter, issues word-aligned fetch requests to instruction memory over a valid/ready channel, and buffers in-order responses in a small FIFO. It presents one 32-bit instruction plus its PC to the decode/control stage, which slices opcode, funct3 and funct7 from it. Taken branches from execute redirect the PC, flush the FIFO and discard in-flight responses.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
// Holds the FIFO entry layout and the word-alignment helper.
package ifu_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; flush wins over push and pop in the same cycle.
// Used both for the instruction buffer and for the in-order request address queue.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_en  = pop && !empty && !flush;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_en = push && !flush && (!full || pop_en);

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_en) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push_en, pop_en})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, in-order response buffer, branch redirect.
// Optional feature macro IFU_MISALIGN_TRAP_EN: misaligned redirect raises a sticky fetch fault.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instruction_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            fetch_fault_o
);
  localparam int INF_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W  = 16;

  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [INF_W-1:0]  inflight_reg, inflight_next, inflight_after;
  logic [INF_W-1:0]  drop_reg, drop_next;
  logic              run_reg;
  logic              fault_active;
  logic [XLEN-1:0]   target_pc;
  logic              req_fire, rsp_keep, rsp_drop, credit_ok;
  logic [SUM_W-1:0]  pending_sum;
  logic [XLEN-1:0]   addr_head;
  fetch_entry_t      push_entry, head_entry;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic [INF_W-1:0]  aq_count;
  logic              aq_empty;
  logic              unused_sigs;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_reg;
  logic misalign;
  assign misalign  = |branch_target_i[1:0];
  assign target_pc = branch_target_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fault_reg <= 1'b0;
    else if (branch_taken_i && misalign) fault_reg <= 1'b1;
  end
  assign fault_active = fault_reg;
`else
  assign target_pc    = align_word(branch_target_i);
  assign fault_active = 1'b0;
`endif

  // Credits: live requests (not yet dropped) plus buffered entries never exceed FIFO_DEPTH.
  assign pending_sum = SUM_W'(inflight_reg) - SUM_W'(drop_reg) + SUM_W'(fifo_count);
  assign credit_ok   = pending_sum < SUM_W'(FIFO_DEPTH);

  assign imem_req_valid_o = run_reg && !branch_taken_i && !fault_active &&
                            (inflight_reg < INF_W'(MAX_OUTSTANDING)) && credit_ok;
  assign imem_req_addr_o  = pc_reg;

  assign req_fire       = imem_req_valid_o && imem_req_ready_i;
  assign rsp_drop       = imem_rsp_valid_i && (drop_reg != '0);
  assign rsp_keep       = imem_rsp_valid_i && (drop_reg == '0);
  assign inflight_after = inflight_reg + INF_W'(req_fire) - INF_W'(imem_rsp_valid_i);

  always_comb begin
    pc_next       = req_fire ? pc_reg + XLEN'(4) : pc_reg;
    inflight_next = inflight_after;
    drop_next     = drop_reg - INF_W'(rsp_drop);
    // Everything still outstanding after this cycle belongs to the old path.
    if (branch_taken_i) begin
      pc_next   = target_pc;
      drop_next = inflight_after;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
      run_reg      <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
      run_reg      <= 1'b1;
    end
  end

  ifu_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_taken_i),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_keep),
    .head_data (addr_head),
    .count     (aq_count),
    .empty     (aq_empty)
  );

  assign push_entry.pc    = addr_head;
  assign push_entry.instr = imem_rsp_data_i;

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_taken_i),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (instr_valid_o && instr_ready_i),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign instr_valid_o = !fifo_empty;
  assign instruction_o = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign instr_pc_o    = fifo_empty ? '0 : head_entry.pc;
  assign fetch_fault_o = fault_active;

  assign unused_sigs = ^{aq_count, aq_empty};
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable in-order memory model.
// A second instance with RESET_PC near the top of memory covers PC wrap.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_ready_i = 1'b1;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        instr_ready_i = 1'b1;
  logic        imem_req_valid_o, instr_valid_o, fetch_fault_o;
  logic [31:0] imem_req_addr_o, instruction_o, instr_pc_o;

  logic        w_branch = 1'b0, w_req_ready = 1'b1, w_rsp_valid = 1'b0, w_instr_ready = 1'b1;
  logic [31:0] w_target = '0, w_rsp_data = '0;
  logic        w_req_valid, w_instr_valid, w_fault;
  logic [31:0] w_addr, w_instr, w_pc;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instruction_o(instruction_o),
    .instr_pc_o(instr_pc_o), .fetch_fault_o(fetch_fault_o)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .branch_taken_i(w_branch), .branch_target_i(w_target),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready),
    .imem_req_addr_o(w_addr), .imem_rsp_valid_i(w_rsp_valid),
    .imem_rsp_data_i(w_rsp_data), .instr_valid_o(w_instr_valid),
    .instr_ready_i(w_instr_ready), .instruction_o(w_instr),
    .instr_pc_o(w_pc), .fetch_fault_o(w_fault)
  );

  // In-order memory: data word is the bitwise inverse of its address.
  always begin
    @(negedge clk);
    if (rst_n && imem_req_valid_o && imem_req_ready_i)
      mq.push_back('{cyc + mem_lat, imem_req_addr_o});
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid_i = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
    end
  end

  logic        w_fire_q;
  logic [31:0] w_addr_q;
  always begin
    @(negedge clk);
    w_fire_q = rst_n && w_req_valid && w_req_ready;
    w_addr_q = w_addr;
    @(posedge clk);
    #1;
    w_rsp_valid = rst_n && w_fire_q;
    w_rsp_data  = ~w_addr_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    branch_taken_i = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    mem_lat = 1;
    instr_ready_i = 1'b0;
    do_reset();
    repeat (4) tick();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid_o); end
    vectors++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid_o); end
    vectors++; if (instruction_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_instruction: got %h expected 00000013", instruction_o); end
    vectors++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h expected 00000000", instr_pc_o); end
    vectors++; if (fetch_fault_o !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fetch_fault_o); end
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_release_req: got %b expected 0", imem_req_valid_o); end
    tick();
    @(negedge clk);
    vectors++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin errors++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid_o, imem_req_addr_o); end
    instr_ready_i = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_pop = 32'h0;
    int npop = 0;
    mem_lat = 1;
    instr_ready_i = 1'b1;
    do_reset();
    for (int c = 0; c < 40 && npop < 8; c++) begin
      @(negedge clk);
      if (c < 2) begin
        vectors++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d: got %b expected 0", c, instr_valid_o); end
      end
      if (c == 2) begin
        vectors++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b expected 1", instr_valid_o); end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        vectors++; if (imem_req_addr_o !== exp_req) begin errors++; $display("FAIL stream_req_addr: got %h expected %h", imem_req_addr_o, exp_req); end
        exp_req += 32'd4;
      end
      if (instr_valid_o && instr_ready_i) begin
        vectors++; if (instr_pc_o !== exp_pop || instruction_o !== ~exp_pop) begin errors++; $display("FAIL stream_pop: got pc=%h i=%h expected pc=%h i=%h", instr_pc_o, instruction_o, exp_pop, ~exp_pop); end
        exp_pop += 32'd4;
        npop++;
      end
      tick();
    end
    vectors++; if (npop != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", npop); end
    $display("test_stream done");
  endtask

  task automatic test_stall();
    logic [31:0] exp_pop = 32'h0;
    int nfire = 0;
    int npop = 0;
    mem_lat = 1;
    instr_ready_i = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req_valid_o && imem_req_ready_i) nfire++;
      tick();
    end
    @(negedge clk);
    vectors++; if (nfire != 2) begin errors++; $display("FAIL stall_fires: got %0d expected 2", nfire); end
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid_o); end
    vectors++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=00000000", instr_valid_o, instr_pc_o); end
    tick();
    instr_ready_i = 1'b1;
    for (int c = 0; c < 30 && npop < 6; c++) begin
      @(negedge clk);
      if (instr_valid_o && instr_ready_i) begin
        vectors++; if (instr_pc_o !== exp_pop || instruction_o !== ~exp_pop) begin errors++; $display("FAIL stall_resume_pop: got pc=%h i=%h expected pc=%h", instr_pc_o, instruction_o, exp_pop); end
        exp_pop += 32'd4;
        npop++;
      end
      tick();
    end
    vectors++; if (npop != 6) begin errors++; $display("FAIL stall_resume_count: got %0d expected 6", npop); end
    $display("test_stall done");
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] exp_pop = 32'h100;
    int npop = 0;
    logic seen_req = 1'b0;
    mem_lat = 3;
    instr_ready_i = 1'b1;
    do_reset();
    tick();
    tick();
    branch_taken_i = 1'b1;
    branch_target_i = 32'h100;
    @(negedge clk);
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL redir_req_in_n: got %b expected 0", imem_req_valid_o); end
    tick();
    branch_taken_i = 1'b0;
    for (int c = 0; c < 30 && npop < 2; c++) begin
      @(negedge clk);
      if (imem_req_valid_o && imem_req_ready_i && !seen_req) begin
        vectors++; if (imem_req_addr_o !== 32'h100) begin errors++; $display("FAIL redir_first_addr: got %h expected 00000100", imem_req_addr_o); end
        seen_req = 1'b1;
      end
      if (instr_valid_o && instr_ready_i) begin
        vectors++; if (instr_pc_o !== exp_pop || instruction_o !== ~exp_pop) begin errors++; $display("FAIL redir_pop: got pc=%h i=%h expected pc=%h", instr_pc_o, instruction_o, exp_pop); end
        exp_pop += 32'd4;
        npop++;
      end
      tick();
    end
    vectors++; if (npop != 2 || !seen_req) begin errors++; $display("FAIL redir_timeout: got pops=%0d req=%b expected pops=2 req=1", npop, seen_req); end
    mem_lat = 1;
    $display("test_redirect_inflight done");
  endtask

  task automatic test_redirect_collide();
    mem_lat = 1;
    instr_ready_i = 1'b1;
    do_reset();
    tick();
    tick();
    branch_taken_i = 1'b1;
    branch_target_i = 32'h200;
    @(negedge clk);
    vectors++; if (instr_valid_o !== 1'b1 || imem_rsp_valid_i !== 1'b1) begin errors++; $display("FAIL collide_setup: got iv=%b rv=%b expected 1 1", instr_valid_o, imem_rsp_valid_i); end
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL collide_req_in_n: got %b expected 0", imem_req_valid_o); end
    tick();
    branch_taken_i = 1'b0;
    @(negedge clk);
    vectors++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL collide_flush: got %b expected 0 (pc=%h)", instr_valid_o, instr_pc_o); end
    vectors++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h200) begin errors++; $display("FAIL collide_target_req: got v=%b a=%h expected v=1 a=00000200", imem_req_valid_o, imem_req_addr_o); end
    tick();
    @(negedge clk);
    vectors++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL collide_latency: got %b expected 0", instr_valid_o); end
    tick();
    @(negedge clk);
    vectors++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instruction_o !== ~32'h200) begin errors++; $display("FAIL collide_new_head: got v=%b pc=%h i=%h expected v=1 pc=00000200", instr_valid_o, instr_pc_o, instruction_o); end
    $display("test_redirect_collide done");
  endtask

  task automatic test_misalign();
    mem_lat = 1;
    instr_ready_i = 1'b1;
    do_reset();
    repeat (3) tick();
    branch_taken_i = 1'b1;
    branch_target_i = 32'h102;
    @(negedge clk);
    vectors++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL misalign_req_in_n: got %b expected 0", imem_req_valid_o); end
    tick();
    branch_taken_i = 1'b0;
    @(negedge clk);
    vectors++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL misalign_flush: got %b expected 0", instr_valid_o); end
`ifdef IFU_MISALIGN_TRAP_EN
    vectors++; if (fetch_fault_o !== 1'b1) begin errors++; $display("FAIL misalign_fault: got %b expected 1", fetch_fault_o); end
    for (int c = 0; c < 6; c++) begin
      vectors++; if (imem_req_valid_o !== 1'b0 || fetch_fault_o !== 1'b1) begin errors++; $display("FAIL misalign_stop c%0d: got v=%b f=%b expected v=0 f=1", c, imem_req_valid_o, fetch_fault_o); end
      tick();
      @(negedge clk);
    end
`else
    vectors++; if (fetch_fault_o !== 1'b0) begin errors++; $display("FAIL misalign_fault: got %b expected 0", fetch_fault_o); end
    vectors++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin errors++; $display("FAIL misalign_aligned_req: got v=%b a=%h expected v=1 a=00000100", imem_req_valid_o, imem_req_addr_o); end
`endif
    $display("test_misalign done");
  endtask

  task automatic test_pc_wrap();
    logic [31:0] wrap_exp [4];
    int idx = 0;
    logic seen_pop = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;
    do_reset();
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk);
      if (w_req_valid && w_req_ready) begin
        vectors++; if (w_addr !== wrap_exp[idx]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", idx, w_addr, wrap_exp[idx]); end
        idx++;
      end
      if (w_instr_valid && w_instr_ready && !seen_pop) begin
        vectors++; if (w_pc !== 32'hFFFF_FFF8 || w_instr !== 32'h0000_0007) begin errors++; $display("FAIL wrap_first_pop: got pc=%h i=%h expected pc=fffffff8 i=00000007", w_pc, w_instr); end
        seen_pop = 1'b1;
      end
      tick();
    end
    vectors++; if (idx != 4 || w_fault !== 1'b0) begin errors++; $display("FAIL wrap_count: got %0d fault=%b expected 4 fault=0", idx, w_fault); end
    $display("test_pc_wrap done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_misalign();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
